// File: rtl/imem_axil_rd_slave_if.sv
// AXI-lite read channel (AR + R) between the fetch unit and the imem responder.
// Latency: none, wires only.
// Backpressure: standard valid/ready on both AR and R.
interface imem_axil_rd_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;

    modport slave (
        input  ARVALID, ARADDR, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );

    modport master (
        output ARVALID, ARADDR, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/imem_axil_rd_slave.sv
// AXI-lite read responder for the instruction memory: one read at a time, 64-bit word returned.
// Latency: RVALID 3+WAIT_CYC cycles after the AR handshake (1 cycle for an out-of-range DECERR).
// Backpressure: ARREADY only while idle; RDATA/RRESP held until RREADY.
module imem_axil_rd_slave #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 64,
    parameter logic [ADDR_W-1:0] BASE     = 32'h80000000,
    parameter logic [ADDR_W-1:0] SIZE     = 32'h08000000,
    parameter int                WAIT_CYC = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    imem_axil_rd_slave_if.slave    bus,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_rdata
);
    localparam int         LP_LSB  = $clog2(DATA_W / 8);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DATA  = 3'd2,
        DELAY = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [3:0]        r_cnt;

    logic              w_accept;
    logic [ADDR_W-1:0] w_offset;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr_aligned;

    // Range check on the raw address; the subtraction form cannot overflow the way BASE+SIZE could.
    assign w_offset       = bus.ARADDR - BASE;
    assign w_in_range     = (bus.ARADDR >= BASE) && (w_offset < SIZE);
    assign w_addr_aligned = {bus.ARADDR[ADDR_W-1:LP_LSB], LP_LSB'(0)};
    assign w_accept       = bus.ARVALID && (r_state == IDLE);

    // Outputs decode from registered state only, so no input reaches RVALID or mem_req combinationally.
    assign bus.ARREADY = (r_state == IDLE);
    assign bus.RVALID  = (r_state == RESP);
    assign bus.RDATA   = r_rdata;
    assign bus.RRESP   = r_rresp;
    assign mem_req     = (r_state == REQ);
    assign mem_addr    = r_addr;

    // State register; reset aborts any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_in_range ? REQ : RESP;
                end
            end
            REQ: begin
                w_next = DATA;
            end
            DATA: begin
                w_next = (WAIT_CYC == 0) ? RESP : DELAY;
            end
            DELAY: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (bus.RREADY) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Address latch, response data/status capture and wait-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_rdata <= '0;
            r_rresp <= 2'b00;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= w_addr_aligned;
                        if (!w_in_range) begin
                            r_rdata <= '0;
                            r_rresp <= 2'b11;
                        end
                    end
                end
                DATA: begin
                    r_rdata <= mem_rdata;
                    r_rresp <= 2'b00;
                    if (WAIT_CYC != 0) begin
                        r_cnt <= LP_WAIT - 4'd1;
                    end
                end
                DELAY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/imem_axil_rd_slave.md
Name: imem_axil_rd_slave

Overview:
AXI-lite read-channel responder that sits in front of the instruction memory and serves the fetch unit's AR/R requests.
- Accepts one read address at a time and aligns it to the 64-bit word.
- Range-checks the address, reads a synchronous single-port memory, applies configurable extra wait cycles, then returns the full 64-bit word.
- The fetch unit selects the 32-bit half itself.

Parameters:
ADDR_W, 32, AXI address width.
DATA_W, 64, data width (bytes per word = DATA_W/8 = 8).
BASE, 32'h80000000, lowest valid byte address.
SIZE, 32'h08000000, valid window size in bytes; valid iff BASE <= addr < BASE+SIZE.
WAIT_CYC, 0, extra cycles (0..15) between memory data capture and RVALID.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous active-high reset.
ARVALID  in  1  read address valid.
ARADDR  in  ADDR_W  read byte address.
ARREADY  out  1  address accepted when high together with ARVALID.
RVALID  out  1  read data valid.
RDATA  out  DATA_W  read data word.
RRESP  out  2  2'b00 OKAY, 2'b11 DECERR.
RREADY  in  1  master accepts data.
mem_req  out  1  one-cycle memory read strobe.
mem_addr  out  ADDR_W  word-aligned memory byte address (low 3 bits zero).
mem_rdata  in  DATA_W  memory data, valid the cycle after mem_req.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset values and reset mid-operation:
  - state=IDLE, ARREADY=1 (combinational from state), RVALID=0, RDATA=0, RRESP=2'b00, mem_req=0, mem_addr=0, wait counter=0.
  - Reset in any state aborts the transaction.
  - No RVALID is produced for an aborted request. mem_req is low the cycle after rst is sampled.
- States: IDLE, REQ, DATA, DELAY, RESP. ARREADY=1 only in IDLE.
- IDLE:
  - On ARVALID&ARREADY, latch addr_q = ARADDR & ~7.
  - If in range, go to REQ.
  - Otherwise go to RESP with RDATA=0, RRESP=2'b11, and no mem_req ever issued.
  - The range check uses the unaligned ARADDR, with width-safe compare (no overflow of BASE+SIZE; compare addr-BASE < SIZE).
- REQ: mem_req=1 and mem_addr=addr_q for exactly this cycle; go to DATA.
- DATA:
  - Capture mem_rdata into the RDATA register; RRESP=2'b00.
  - If WAIT_CYC==0 go to RESP, else load counter=WAIT_CYC-1 and go to DELAY.
- DELAY: counter decrements each cycle; go to RESP when counter==0 at the edge.
- RESP:
  - RVALID=1. RDATA and RRESP are held stable while RREADY=0.
  - On RVALID&RREADY, go to IDLE, and RVALID=0 in the next cycle.
- Latency, with handshake cycle = cycle 0:
  - mem_req is high in cycle 1.
  - RVALID first goes high in cycle 3+WAIT_CYC, or in cycle 1 for DECERR.
- Throughput: one outstanding transaction.
  - With RREADY held high, the next ARREADY is high the cycle after the R handshake.
  - Minimum spacing is 4+WAIT_CYC cycles per read.
- Bus rule: ARVALID is ignored outside IDLE. The address is not latched, and a held ARVALID is accepted on return to IDLE.
- No combinational path from ARVALID/RREADY to RVALID, RDATA or mem_req. RDATA/RRESP are registered.
- The mem_rdata value in any cycle other than DATA is ignored.

Test Plan:
1. Basic read, WAIT_CYC=0:
   - Stimulus: rst released, ARVALID=1, ARADDR=0x80000000 in cycle 0; memory word 0x00100093_00000297; RREADY=1.
   - Required: mem_req=1 with mem_addr=0x80000000 in cycle 1 only; RVALID=1 in cycle 3 with RDATA=0x00100093_00000297 and RRESP=0; ARREADY=1 in cycle 4.
2. Unaligned address:
   - Stimulus: ARADDR=0x80000004.
   - Required: mem_addr=0x80000000; RDATA is the full word at 0x80000000.
3. Backpressure, WAIT_CYC=3:
   - Stimulus: read 0x80000010 with RREADY=0 for 5 cycles after RVALID rises.
   - Required: RVALID rises in cycle 6; RDATA/RRESP stable for all 6 RVALID cycles; ARREADY=0 throughout; completes when RREADY=1.
4. Out of range:
   - Stimulus: ARADDR=0x7FFFFFF8, then 0x88000000.
   - Required: no mem_req; RVALID in cycle 1; RDATA=0; RRESP=2'b11. Address 0x87FFFFF8 returns RRESP=0.
5. Held ARVALID / back-to-back:
   - Stimulus: ARVALID held high with ARADDR=0x80000000 then 0x80000008, RREADY=1.
   - Required: second accept exactly one cycle after the first R handshake; exactly two mem_req pulses; no address lost or duplicated.
6. Reset mid-transaction:
   - Stimulus: assert rst in the DATA cycle.
   - Required: RVALID never rises for that request; all outputs at reset values next cycle; a fresh read then completes normally.
